// File: rtl/mem_writeback.sv
// Memory/writeback stage: issues one data-memory access per load/store, extracts
// load data, and registers the writeback value that also feeds forwarding.
module mem_writeback #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ex_valid,
  input  logic [31:0]       ex_result,
  input  logic [31:0]       ex_store_data,
  input  logic [2:0]        ex_funct3,
  input  logic              ex_is_load,
  input  logic              ex_is_store,
  input  logic [4:0]        ex_rd,
  input  logic              ex_reg_we,
  output logic              stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  output logic [3:0]        dmem_wmask,
  input  logic              dmem_ready,
  input  logic [31:0]       dmem_rdata,
  output logic [31:0]       wb_data,
  output logic [4:0]        wb_rd,
  output logic              wb_we,
  output logic              misaligned
);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACCESS = 1'b1
  } state_t;

  state_t            r_state;
  logic [ADDR_W-3:0] r_word;
  logic [1:0]        r_lane;
  logic [2:0]        r_funct3;
  logic [31:0]       r_wdata;
  logic [3:0]        r_wmask;
  logic [4:0]        r_rd;
  logic              r_reg_we;
  logic              r_is_store;

  logic [31:0]       r_wb_data;
  logic [4:0]        r_wb_rd;
  logic              r_wb_we;
  logic              r_misaligned;

  // One-deep holding slot for an ALU result accepted on the same edge a load
  // writes back; it drains into the writeback registers on the following edge.
  logic              r_pend_valid;
  logic [31:0]       r_pend_data;
  logic [4:0]        r_pend_rd;
  logic              r_pend_we;

  logic [ADDR_W-1:0] w_addr;
  logic              w_misaligned;
  logic [31:0]       w_st_data;
  logic [3:0]        w_st_mask;
  logic [7:0]        w_ld_byte;
  logic [15:0]       w_ld_half;
  logic [31:0]       w_ld_data;
  logic              w_in_access;
  logic              w_done;
  logic              w_accept;
  logic              w_is_mem;
  logic              w_slot_busy;
  logic              w_alu_we;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    w_addr       = ADDR_W'(ex_result);
    w_misaligned = 1'b0;
    w_st_data    = ex_store_data;
    w_st_mask    = 4'b1111;
    case (ex_funct3[1:0])
      2'b00: begin
        w_st_data = {4{ex_store_data[7:0]}};
        w_st_mask = 4'b0001 << w_addr[1:0];
      end
      2'b01: begin
        w_misaligned = w_addr[0];
        w_st_data    = {2{ex_store_data[15:0]}};
        w_st_mask    = 4'b0011 << w_addr[1:0];
      end
      2'b10:   w_misaligned = |w_addr[1:0];
      default: ;
    endcase
  end

  always_comb begin
    case (r_lane)
      2'd0:    w_ld_byte = dmem_rdata[7:0];
      2'd1:    w_ld_byte = dmem_rdata[15:8];
      2'd2:    w_ld_byte = dmem_rdata[23:16];
      default: w_ld_byte = dmem_rdata[31:24];
    endcase
    w_ld_half = r_lane[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (r_funct3)
      3'b000:  w_ld_data = {{24{w_ld_byte[7]}}, w_ld_byte};
      3'b001:  w_ld_data = {{16{w_ld_half[15]}}, w_ld_half};
      3'b100:  w_ld_data = {24'b0, w_ld_byte};
      3'b101:  w_ld_data = {16'b0, w_ld_half};
      default: w_ld_data = dmem_rdata;
    endcase
  end

  assign w_in_access = (r_state == S_ACCESS);
  assign w_done      = w_in_access & dmem_ready;
  assign w_accept    = ex_valid & (~w_in_access | dmem_ready);
  assign w_is_mem    = ex_is_load | ex_is_store;
  assign w_alu_we    = ex_reg_we & (ex_rd != 5'd0);
  assign w_slot_busy = (w_done & ~r_is_store) | (~w_in_access & r_pend_valid);

  // NOTE: sequential state uses non-blocking assignments only; later assignments
  // in this block deliberately override earlier ones (e.g. back-to-back ACCESS).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_word       <= '0;
      r_lane       <= 2'b0;
      r_funct3     <= 3'b0;
      r_wdata      <= 32'b0;
      r_wmask      <= 4'b0;
      r_rd         <= 5'b0;
      r_reg_we     <= 1'b0;
      r_is_store   <= 1'b0;
      r_wb_data    <= 32'b0;
      r_wb_rd      <= 5'b0;
      r_wb_we      <= 1'b0;
      r_misaligned <= 1'b0;
      r_pend_valid <= 1'b0;
      r_pend_data  <= 32'b0;
      r_pend_rd    <= 5'b0;
      r_pend_we    <= 1'b0;
    end else begin
      r_wb_we      <= 1'b0;
      r_misaligned <= 1'b0;
      r_pend_valid <= 1'b0;

      if (w_done) begin
        r_state <= S_IDLE;
        if (!r_is_store) begin
          r_wb_data <= w_ld_data;
          r_wb_rd   <= r_rd;
          r_wb_we   <= r_reg_we & (r_rd != 5'd0);
        end
      end

      if (!w_in_access && r_pend_valid) begin
        r_wb_data <= r_pend_data;
        r_wb_rd   <= r_pend_rd;
        r_wb_we   <= r_pend_we;
      end

      if (w_accept) begin
        if (w_is_mem) begin
          if (w_misaligned) begin
            r_misaligned <= 1'b1;
          end else begin
            r_state    <= S_ACCESS;
            r_word     <= w_addr[ADDR_W-1:2];
            r_lane     <= w_addr[1:0];
            r_funct3   <= ex_funct3;
            r_wdata    <= w_st_data;
            r_wmask    <= ex_is_store ? w_st_mask : 4'b0;
            r_rd       <= ex_rd;
            r_reg_we   <= ex_reg_we;
            r_is_store <= ex_is_store;
          end
        end else if (w_slot_busy) begin
          r_pend_valid <= 1'b1;
          r_pend_data  <= ex_result;
          r_pend_rd    <= ex_rd;
          r_pend_we    <= w_alu_we;
        end else begin
          r_wb_data <= ex_result;
          r_wb_rd   <= ex_rd;
          r_wb_we   <= w_alu_we;
        end
      end
    end
  end

  assign stall      = w_in_access & ~dmem_ready;
  assign dmem_req   = w_in_access;
  assign dmem_we    = w_in_access & r_is_store;
  assign dmem_addr  = {r_word, 2'b00};
  assign dmem_wdata = r_wdata;
  assign dmem_wmask = w_in_access ? r_wmask : 4'b0;
  assign wb_data    = r_wb_data;
  assign wb_rd      = r_wb_rd;
  assign wb_we      = r_wb_we;
  assign misaligned = r_misaligned;

endmodule

// File: tb/tb_mem_writeback.sv
// Self-checking bench for mem_writeback: directed scenarios, then randomized
// traffic against an in-order transaction model of the stage.
module tb_mem_writeback;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ex_valid;
  logic [31:0] ex_result;
  logic [31:0] ex_store_data;
  logic [2:0]  ex_funct3;
  logic        ex_is_load;
  logic        ex_is_store;
  logic [4:0]  ex_rd;
  logic        ex_reg_we;
  logic        stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wmask;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_we;
  logic        misaligned;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [31:0] result;
    logic [31:0] sdata;
    logic [2:0]  f3;
    logic        ld;
    logic        st;
    logic [4:0]  rd;
    logic        we;
  } ins_t;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  rd;
  } wb_t;

  wb_t wb_q[$];

  mem_writeback dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .ex_valid     (ex_valid),
    .ex_result    (ex_result),
    .ex_store_data(ex_store_data),
    .ex_funct3    (ex_funct3),
    .ex_is_load   (ex_is_load),
    .ex_is_store  (ex_is_store),
    .ex_rd        (ex_rd),
    .ex_reg_we    (ex_reg_we),
    .stall        (stall),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_wmask   (dmem_wmask),
    .dmem_ready   (dmem_ready),
    .dmem_rdata   (dmem_rdata),
    .wb_data      (wb_data),
    .wb_rd        (wb_rd),
    .wb_we        (wb_we),
    .misaligned   (misaligned)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input ins_t i, input bit v);
    ex_valid      = v;
    ex_result     = i.result;
    ex_store_data = i.sdata;
    ex_funct3     = i.f3;
    ex_is_load    = i.ld;
    ex_is_store   = i.st;
    ex_rd         = i.rd;
    ex_reg_we     = i.we;
  endtask

  function automatic ins_t mk(input logic [31:0] res, input logic [31:0] sd, input logic [2:0] f3,
                              input logic ld, input logic st, input logic [4:0] rd, input logic we);
    ins_t i;
    i.result = res; i.sdata = sd; i.f3 = f3; i.ld = ld; i.st = st; i.rd = rd; i.we = we;
    return i;
  endfunction

  function automatic int access_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      2'b10:   return 4;
      default: return 1;
    endcase
  endfunction

  function automatic bit is_misaligned(input ins_t i);
    return (int'(i.result[1:0]) % access_size(i.f3)) != 0;
  endfunction

  function automatic logic [3:0] exp_mask(input ins_t i);
    int m;
    m = ((1 << access_size(i.f3)) - 1) << int'(i.result[1:0]);
    return i.st ? 4'(m) : 4'b0;
  endfunction

  function automatic logic [31:0] exp_wdata(input ins_t i);
    case (access_size(i.f3))
      1:       return {24'b0, i.sdata[7:0]} * 32'h0101_0101;
      2:       return {16'b0, i.sdata[15:0]} * 32'h0001_0001;
      default: return i.sdata;
    endcase
  endfunction

  function automatic logic [31:0] load_value(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] word);
    logic [31:0] sh;
    logic [31:0] v;
    sh = word >> (8 * int'(addr[1:0]));
    case (f3)
      3'd0: begin v = sh & 32'hFF;   if (v[7])  v = v - 32'h100;   end
      3'd1: begin v = sh & 32'hFFFF; if (v[15]) v = v - 32'h10000; end
      3'd4: v = sh & 32'hFF;
      3'd5: v = sh & 32'hFFFF;
      default: v = word;
    endcase
    return v;
  endfunction

  function automatic ins_t rand_ins();
    ins_t i;
    int   kind;
    logic [2:0] ld_codes [5];
    ld_codes = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    kind = $urandom_range(0, 2);
    i.result = $urandom;
    i.sdata  = $urandom;
    i.rd     = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    i.we     = ($urandom_range(0, 4) != 0);
    i.ld     = (kind == 1);
    i.st     = (kind == 2);
    i.f3     = (kind == 1) ? ld_codes[$urandom_range(0, 4)] : 3'($urandom_range(0, 2));
    if (kind != 0 && $urandom_range(0, 1) == 0) i.result[1:0] = 2'b00;
    return i;
  endfunction

  ins_t idle_ins;
  ins_t cur;
  ins_t req;
  wb_t  e;
  bit   have;
  bit   busy;
  bit   exp_mis;
  bit   exp_stall;
  bit   drain;
  localparam int N_RAND = 3000;

  initial begin
    idle_ins   = mk(32'h0, 32'h0, 3'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    reset_n    = 1'b0;
    dmem_ready = 1'b0;
    dmem_rdata = 32'h0;
    drive(idle_ins, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("rst_wb_we", 32'(wb_we), 32'h0);
    check("rst_wb_data", wb_data, 32'h0);
    check("rst_stall", 32'(stall), 32'h0);
    check("rst_dmem_req", 32'(dmem_req), 32'h0);
    reset_n = 1'b1;

    // ALU writeback, latency one, single-cycle pulse
    drive(mk(32'h1234_5678, 32'h0, 3'd0, 1'b0, 1'b0, 5'd5, 1'b1), 1'b1);
    @(negedge clk);
    check("alu_wb_data", wb_data, 32'h1234_5678);
    check("alu_wb_rd", 32'(wb_rd), 32'd5);
    check("alu_wb_we", 32'(wb_we), 32'h1);
    check("alu_no_req", 32'(dmem_req), 32'h0);
    drive(idle_ins, 1'b0);
    @(negedge clk);
    check("alu_we_once", 32'(wb_we), 32'h0);
    check("idle_hold_data", wb_data, 32'h1234_5678);

    // LB 0x103 with three wait states
    drive(mk(32'h0000_0103, 32'h0, 3'd0, 1'b1, 1'b0, 5'd1, 1'b1), 1'b1);
    @(negedge clk);
    drive(idle_ins, 1'b0);
    for (int k = 0; k < 3; k++) begin
      check("lb_stall", 32'(stall), 32'h1);
      check("lb_req", 32'(dmem_req), 32'h1);
      check("lb_addr", dmem_addr, 32'h0000_0100);
      check("lb_we", 32'(dmem_we), 32'h0);
      check("lb_wb_we_wait", 32'(wb_we), 32'h0);
      @(negedge clk);
    end
    dmem_ready = 1'b1;
    dmem_rdata = 32'h80FF_0000;
    #1;
    check("lb_stall_drop", 32'(stall), 32'h0);
    @(negedge clk);
    dmem_ready = 1'b0;
    check("lb_wb_data", wb_data, 32'hFFFF_FF80);
    check("lb_wb_we", 32'(wb_we), 32'h1);
    check("lb_req_done", 32'(dmem_req), 32'h0);

    // SH 0x202
    drive(mk(32'h0000_0202, 32'h0000_BEEF, 3'd1, 1'b0, 1'b1, 5'd2, 1'b0), 1'b1);
    @(negedge clk);
    drive(idle_ins, 1'b0);
    check("sh_we", 32'(dmem_we), 32'h1);
    check("sh_mask", 32'(dmem_wmask), 32'hC);
    check("sh_wdata", dmem_wdata, 32'hBEEF_BEEF);
    check("sh_addr", dmem_addr, 32'h0000_0200);
    dmem_ready = 1'b1;
    @(negedge clk);
    dmem_ready = 1'b0;
    check("sh_wb_we", 32'(wb_we), 32'h0);
    check("sh_req_done", 32'(dmem_req), 32'h0);

    // LW 0x101 misaligned
    drive(mk(32'h0000_0101, 32'h0, 3'd2, 1'b1, 1'b0, 5'd7, 1'b1), 1'b1);
    @(negedge clk);
    drive(idle_ins, 1'b0);
    check("mis_pulse", 32'(misaligned), 32'h1);
    check("mis_no_req", 32'(dmem_req), 32'h0);
    check("mis_wb_we", 32'(wb_we), 32'h0);
    @(negedge clk);
    check("mis_pulse_end", 32'(misaligned), 32'h0);
    check("mis_no_req2", 32'(dmem_req), 32'h0);

    // LHU then ADD back-to-back
    drive(mk(32'h0000_0002, 32'h0, 3'd5, 1'b1, 1'b0, 5'd4, 1'b1), 1'b1);
    @(negedge clk);
    dmem_ready = 1'b1;
    dmem_rdata = 32'h8001_0000;
    drive(mk(32'd7, 32'h0, 3'd0, 1'b0, 1'b0, 5'd3, 1'b1), 1'b1);
    @(negedge clk);
    dmem_ready = 1'b0;
    drive(idle_ins, 1'b0);
    check("b2b_load_data", wb_data, 32'h0000_8001);
    check("b2b_load_rd", 32'(wb_rd), 32'd4);
    check("b2b_load_we", 32'(wb_we), 32'h1);
    @(negedge clk);
    check("b2b_add_data", wb_data, 32'd7);
    check("b2b_add_rd", 32'(wb_rd), 32'd3);
    check("b2b_add_we", 32'(wb_we), 32'h1);
    @(negedge clk);
    check("b2b_we_end", 32'(wb_we), 32'h0);

    // Reset in the middle of an access
    drive(mk(32'h0000_0040, 32'h0, 3'd2, 1'b1, 1'b0, 5'd6, 1'b1), 1'b1);
    @(negedge clk);
    drive(idle_ins, 1'b0);
    check("rst_acc_req", 32'(dmem_req), 32'h1);
    #2 reset_n = 1'b0;
    #1;
    check("arst_stall", 32'(stall), 32'h0);
    check("arst_req", 32'(dmem_req), 32'h0);
    check("arst_we", 32'(dmem_we), 32'h0);
    check("arst_mask", 32'(dmem_wmask), 32'h0);
    check("arst_wb_data", wb_data, 32'h0);
    check("arst_wb_rd", 32'(wb_rd), 32'h0);
    check("arst_wb_we", 32'(wb_we), 32'h0);
    check("arst_mis", 32'(misaligned), 32'h0);
    @(negedge clk);
    dmem_ready = 1'b1;
    dmem_rdata = 32'hDEAD_BEEF;
    reset_n    = 1'b1;
    @(negedge clk);
    check("post_rst_wb_we", 32'(wb_we), 32'h0);
    check("post_rst_req", 32'(dmem_req), 32'h0);
    dmem_ready = 1'b0;
    drive(mk(32'h0000_00A5, 32'h0, 3'd0, 1'b0, 1'b0, 5'd9, 1'b1), 1'b1);
    @(negedge clk);
    drive(idle_ins, 1'b0);
    check("post_rst_alu_data", wb_data, 32'h0000_00A5);
    check("post_rst_alu_we", 32'(wb_we), 32'h1);
    @(negedge clk);

    // Randomized traffic against the transaction model
    have    = 1'b0;
    busy    = 1'b0;
    exp_mis = 1'b0;
    cur     = idle_ins;
    req     = idle_ins;
    for (int cyc = 0; cyc < N_RAND + 60; cyc++) begin
      @(negedge clk);
      if (wb_we) begin
        if (wb_q.size() == 0) begin
          check("rnd_wb_spurious", 32'(wb_we), 32'h0);
        end else begin
          e = wb_q.pop_front();
          check("rnd_wb_data", wb_data, e.data);
          check("rnd_wb_rd", 32'(wb_rd), 32'(e.rd));
        end
      end
      check("rnd_misaligned", 32'(misaligned), 32'(exp_mis));
      exp_mis = 1'b0;

      drain      = (cyc >= N_RAND);
      dmem_ready = busy ? (drain || $urandom_range(0, 2) == 0) : ($urandom_range(0, 1) == 1);
      dmem_rdata = $urandom;
      if (!have && !drain && $urandom_range(0, 3) != 0) begin
        cur  = rand_ins();
        have = 1'b1;
      end
      drive(have ? cur : idle_ins, have);
      #1;
      exp_stall = busy && !dmem_ready;
      check("rnd_stall", 32'(stall), 32'(exp_stall));
      check("rnd_req", 32'(dmem_req), 32'(busy));
      if (busy) begin
        check("rnd_addr", dmem_addr, {req.result[31:2], 2'b00});
        check("rnd_we", 32'(dmem_we), 32'(req.st));
        check("rnd_mask", 32'(dmem_wmask), 32'(exp_mask(req)));
        if (req.st) check("rnd_wdata", dmem_wdata, exp_wdata(req));
      end

      if (busy && dmem_ready) begin
        busy = 1'b0;
        if (!req.st && req.we && req.rd != 5'd0)
          wb_q.push_back({load_value(req.f3, req.result, dmem_rdata), req.rd});
      end
      if (have && !exp_stall) begin
        have = 1'b0;
        if (cur.ld || cur.st) begin
          if (is_misaligned(cur)) exp_mis = 1'b1;
          else begin
            busy = 1'b1;
            req  = cur;
          end
        end else if (cur.we && cur.rd != 5'd0) begin
          wb_q.push_back({cur.result, cur.rd});
        end
      end
    end
    check("rnd_drain_queue", 32'(wb_q.size()), 32'h0);
    check("rnd_drain_busy", 32'(busy), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_writeback.md
MEM_WRITEBACK -- requirements
Module: mem_writeback

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, width of dmem_addr.
REQ-002 SHALL have ports, clock and reset first:
 clk  in  1  single clock; all state updates on rising edge
 reset_n  in  1  asynchronous, active-low reset
 ex_valid  in  1  execute stage presents an instruction this cycle
 ex_result  in  32  ALU result: memory address for load/store, writeback value otherwise
 ex_store_data  in  32  forwarded rs2 value for stores
 ex_funct3  in  3  load/store size/sign code
 ex_is_load  in  1  instruction is a load
 ex_is_store  in  1  instruction is a store
 ex_rd  in  5  destination register
 ex_reg_we  in  1  instruction writes rd
 stall  out  1  upstream SHALL hold its outputs while high
 dmem_req  out  1  data memory request valid
 dmem_we  out  1  request is a write
 dmem_addr  out  ADDR_W  word-aligned address (bits[1:0] = 0)
 dmem_wdata  out  32  store data shifted into byte lanes
 dmem_wmask  out  4  byte-lane write enables
 dmem_ready  in  1  memory accepts request; read data valid in the same cycle
 dmem_rdata  in  32  read word
 wb_data  out  32  writeback value; execute stage's forwarding source
 wb_rd  out  5  writeback destination
 wb_we  out  1  register-file write enable, one cycle per instruction
 misaligned  out  1  one-cycle pulse on a misaligned access

Function
REQ-003 SHALL implement FSM states IDLE and ACCESS; reset state IDLE.
REQ-004 IDLE, ex_valid=1, neither load nor store: SHALL register ex_result to wb_data, ex_rd to wb_rd, and ex_reg_we && ex_rd!=0 to wb_we on the next edge (latency 1), remaining in IDLE.
REQ-005 IDLE, ex_valid=1, load or store, aligned: SHALL latch address, funct3, shifted data, mask, rd, reg_we and type into a stage register and enter ACCESS; wb_we SHALL be 0 on that edge.
REQ-006 ACCESS: dmem_req=1 and stall=1 every cycle until dmem_ready=1; dmem_addr/we/wdata/wmask SHALL be stable while waiting.
REQ-007 ACCESS and dmem_ready=1: SHALL drop stall combinationally that cycle and return to IDLE on the next edge; a load SHALL write extended data to wb_data with wb_we = latched reg_we && rd!=0; a store SHALL set wb_we=0.
REQ-008 Returning from ACCESS, an instruction presented by upstream in the dmem_ready cycle SHALL be accepted per REQ-004/REQ-005 at that same edge (back-to-back, no bubble).
REQ-009 IDLE, ex_valid=0: wb_we SHALL be 0 next cycle; wb_data and wb_rd SHALL hold.
REQ-010 dmem_req SHALL be 0 in IDLE; stall SHALL be 0 in IDLE.
REQ-011 Alignment: halfword (funct3[1:0]=01) requires addr[0]=0; word (10) requires addr[1:0]=00; byte is always aligned.
REQ-012 Misaligned load/store: SHALL not enter ACCESS, SHALL not issue dmem_req, SHALL set wb_we=0, SHALL pulse misaligned for exactly one cycle after acceptance.
REQ-013 Store lanes: SB mask 0001<<a[1:0], data byte replicated to all lanes; SH mask 0011<<a[1:0], halfword replicated; SW mask 1111, data unmodified.
REQ-014 Load extract, 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU: select byte/half by latched addr[1:0]; LB/LH sign-extend; LBU/LHU zero-extend; other codes return the full word.
REQ-015 wb_data, wb_rd, wb_we SHALL be registered outputs; stall SHALL derive only from state and dmem_ready.

Reset
REQ-016 reset_n=0 SHALL immediately force state IDLE and wb_data=0, wb_rd=0, wb_we=0, misaligned=0, dmem_req=0, dmem_we=0, dmem_wmask=0, stall=0, regardless of clk.
REQ-017 Reset asserted during ACCESS SHALL abandon the access with no writeback; the first edge after reset_n rises SHALL accept new instructions normally.

Verification
REQ-018 ALU op ex_result=0x1234_5678, rd=5, reg_we=1 -> next cycle wb_data=0x1234_5678, wb_rd=5, wb_we=1 for one cycle.
REQ-019 LB addr 0x103, dmem_ready after 3 wait cycles, rdata=0x80FF_0000 -> stall high 3 cycles, dmem_addr=0x100, then wb_data=0xFFFF_FF80, wb_we=1.
REQ-020 SH addr 0x202, data 0x0000_BEEF -> dmem_we=1, wmask=1100, wdata=0xBEEF_BEEF, wb_we=0.
REQ-021 LW addr 0x101 -> misaligned pulses once, dmem_req never asserts, wb_we=0.
REQ-022 LHU (addr 0x2, rdata 0x8001_0000, ready immediate) followed by ADD (result 7, rd 3) -> wb_data=0x0000_8001 then wb_data=7 on consecutive cycles.
REQ-023 reset_n low mid-ACCESS -> all outputs zero asynchronously; no wb_we pulse after release.
